// File: rtl/fp_norm_pkg.sv
// Shared types and default widths for the post-addition normaliser.
// fp_normalize_pipe builds its stage-1 payload from its own parameters; s1_payload_t
// below has the same field layout at the default widths.
package fp_norm_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int TAG_W_DEF  = 4;
  localparam int LZC_W_DEF  = $clog2(MANT_W_DEF + 1);

  // Stage-1 payload at the default widths.
  typedef struct packed {
    logic [MANT_W_DEF:0]    sum;
    logic [EXP_W_DEF-1:0]   exp;
    logic                   sign;
    logic [TAG_W_DEF-1:0]   tag;
    logic                   carry;
    logic                   is_zero;
    logic [LZC_W_DEF-1:0]   lzc;
  } s1_payload_t;

  // Result flags. At most one of them is set for any beat.
  typedef struct packed {
    logic zero;
    logic ovf;
    logic unf;
  } norm_flags_t;

endpackage

// File: rtl/fp_normalize_pipe_lzc.sv
// Combinational leading-zero counter. Returns W when the input is all zeros.
module lzc_count #(
  parameter int W = 24
) (
  input  logic [W-1:0]             din,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int CW = $clog2(W + 1);

  // Scan from the LSB upwards so that the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage post-addition normaliser. S1 registers the beat together with its carry,
// zero and leading-zero information. S2 shifts the mantissa, adjusts the exponent and sets the flags.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   in_sum,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_round,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam int LZC_W = $clog2(MANT_W + 1);
  // The width is wide enough for in_exp+1 and for a full lzc, so comparisons never wrap.
  localparam int XW = (EXP_W + 1 > LZC_W + 1) ? EXP_W + 1 : LZC_W + 1;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic [MANT_W:0]    sum;
    logic [EXP_W-1:0]   exp;
    logic               sign;
    logic [TAG_W-1:0]   tag;
    logic               carry;
    logic               is_zero;
    logic [LZC_W-1:0]   lzc;
  } s1_t;

  s1_t         s1_d, s1_q;
  logic        s1_valid, s2_valid;
  logic        s1_adv, s2_adv;
  logic [LZC_W-1:0] lzc_w;
  norm_flags_t flags_q, n_flags;

  logic [MANT_W-1:0] n_mant;
  logic [EXP_W-1:0]  n_exp;
  logic              n_round;
  logic [XW-1:0]     exp_x, exp_inc, lzc_x, exp_diff, clamp_sh;

  // Handshake: a beat moves on a rising edge where valid && ready. A stage takes a new beat
  // when the stage is empty or its own beat leaves. in_ready depends only on registers and
  // out_ready. It never depends on in_valid.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_zero  = flags_q.zero;
  assign out_ovf   = flags_q.ovf;
  assign out_unf   = flags_q.unf;

  lzc_count #(.W(MANT_W)) u_lzc (
    .din (in_sum[MANT_W-1:0]),
    .cnt (lzc_w)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.sum     = in_sum;
    s1_d.exp     = in_exp;
    s1_d.sign    = in_sign;
    s1_d.tag     = in_tag;
    s1_d.carry   = in_sum[MANT_W];
    s1_d.is_zero = (in_sum == '0);
    s1_d.lzc     = lzc_w;
  end

  always_comb begin
    exp_x    = XW'(s1_q.exp);
    exp_inc  = exp_x + XW'(1);
    lzc_x    = XW'(s1_q.lzc);
    exp_diff = exp_x - lzc_x;
    clamp_sh = (exp_x == '0) ? '0 : exp_x - XW'(1);
    n_mant   = '0;
    n_exp    = '0;
    n_round  = 1'b0;
    n_flags  = '0;
    if (s1_q.carry) begin
      // An exponent that reaches the reserved all-ones code saturates to infinity.
      if (exp_inc >= EXP_MAX) begin
        n_exp       = '1;
        n_flags.ovf = 1'b1;
      end else begin
        n_mant  = s1_q.sum[MANT_W:1];
        n_round = s1_q.sum[0];
        n_exp   = exp_inc[EXP_W-1:0];
      end
    end else if (s1_q.is_zero) begin
      n_flags.zero = 1'b1;
    end else if (exp_x > lzc_x) begin
      n_mant = s1_q.sum[MANT_W-1:0] << s1_q.lzc;
      n_exp  = exp_diff[EXP_W-1:0];
    end else begin
      // Denormal clamp: shift only as far as the exponent allows, then pin it to zero.
      n_mant      = s1_q.sum[MANT_W-1:0] << clamp_sh;
      n_flags.unf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      s2_valid  <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_sign  <= 1'b0;
      out_tag   <= '0;
      out_round <= 1'b0;
      flags_q   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_mant  <= n_mant;
          out_exp   <= n_exp;
          out_sign  <= s1_q.sign;
          out_tag   <= s1_q.tag;
          out_round <= n_round;
          flags_q   <= n_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed and random stimulus for fp_normalize_pipe, with a queue scoreboard that checks
// every output beat.
module tb_fp_normalize_pipe;

  localparam int MW = 24;
  localparam int EW = 8;
  localparam int TW = 4;
  localparam int OW = MW + EW + 1 + TW + 4;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [MW:0]   in_sum;
  logic [EW-1:0] in_exp;
  logic          in_sign;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_sign;
  logic [TW-1:0] out_tag;
  logic          out_round, out_zero, out_ovf, out_unf;
  logic [OW-1:0] obs_word;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];

  fp_normalize_pipe #(.MANT_W(MW), .EXP_W(EW), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_exp    (in_exp),
    .in_sign   (in_sign),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_sign  (out_sign),
    .out_tag   (out_tag),
    .out_round (out_round),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  assign obs_word = {out_mant, out_exp, out_sign, out_tag, out_round, out_zero, out_ovf, out_unf};

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [OW-1:0] pack(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                         input logic s, input logic [TW-1:0] t, input logic r,
                                         input logic z, input logic o, input logic u);
    return {m, e, s, t, r, z, o, u};
  endfunction

  // Reference model, written from the normalisation rules.
  function automatic logic [OW-1:0] model(input logic [MW:0] sum, input logic [EW-1:0] e,
                                          input logic s, input logic [TW-1:0] t);
    int lz;
    int sh;
    bit found;
    logic [MW-1:0] m;
    logic [EW-1:0] eo;
    logic r, z, o, u;
    lz = 0; sh = 0; found = 0; m = '0; eo = '0; r = 0; z = 0; o = 0; u = 0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (sum[i]) found = 1;
      else if (!found) lz++;
    end
    if (sum[MW]) begin
      if (e == 8'hFE) begin
        eo = 8'hFF;
        o = 1;
      end else begin
        m = sum[MW:1];
        r = sum[0];
        eo = e + 8'd1;
      end
    end else if (sum == '0) begin
      z = 1;
    end else if (int'(e) > lz) begin
      m = sum[MW-1:0] << lz;
      eo = EW'(int'(e) - lz);
    end else begin
      sh = (e == '0) ? 0 : int'(e) - 1;
      m = sum[MW-1:0] << sh;
      u = 1;
    end
    return {m, eo, s, t, r, z, o, u};
  endfunction

  // Scoreboard: compare each completed output handshake with the oldest expected beat.
  always @(negedge clk) begin : monitor
    logic [OW-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", 64'(obs_word), 64'(e));
      end
    end
  end

  // Driver: hold one beat until it is accepted, then record its expected result.
  task automatic drive(input logic [MW:0] sum, input logic [EW-1:0] e, input logic s,
                       input logic [TW-1:0] t, input logic [OW-1:0] expv);
    int n;
    in_valid = 1'b1; in_sum = sum; in_exp = e; in_sign = s; in_tag = t;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("drive_timeout", 64'(in_ready), 64'(1));
    else exp_q.push_back(expv);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [OW-1:0] snap;
    logic [MW:0]   rs;
    int nxt;
    int stale;
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_exp = '0; in_sign = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_word", 64'(obs_word), 64'(0));
    @(posedge clk); #1;

    // Carry case with a 2-cycle latency check
    in_valid = 1'b1; in_sum = 25'h1800001; in_exp = 8'h80; in_sign = 1'b0; in_tag = 4'd1;
    @(negedge clk);
    check("carry_accept", 64'(in_ready), 64'(1));
    exp_q.push_back(pack(24'hC00000, 8'h81, 0, 4'd1, 1, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("latency_two", 64'(out_valid), 64'(1));
    @(posedge clk); #1;

    // Directed cases and boundaries
    drive(25'h0100000, 8'h80, 1, 4'd2, pack(24'h800000, 8'h7D, 1, 4'd2, 0, 0, 0, 0));
    drive(25'h0000000, 8'h90, 0, 4'd3, pack(24'h000000, 8'h00, 0, 4'd3, 0, 1, 0, 0));
    drive(25'h1000000, 8'hFE, 0, 4'd4, pack(24'h000000, 8'hFF, 0, 4'd4, 0, 0, 1, 0));
    drive(25'h0000100, 8'h05, 1, 4'd5, pack(24'h001000, 8'h00, 1, 4'd5, 0, 0, 0, 1));
    drive(25'h0000100, 8'h00, 0, 4'd6, pack(24'h000100, 8'h00, 0, 4'd6, 0, 0, 0, 1));
    drive(25'h0100000, 8'h03, 0, 4'd7, pack(24'h400000, 8'h00, 0, 4'd7, 0, 0, 0, 1));
    drive(25'h0100000, 8'h04, 1, 4'd8, pack(24'h800000, 8'h01, 1, 4'd8, 0, 0, 0, 0));
    drive(25'h1FFFFFF, 8'hFD, 0, 4'd9, pack(24'hFFFFFF, 8'hFE, 0, 4'd9, 1, 0, 0, 0));
    drive(25'h0800000, 8'h01, 1, 4'hA, pack(24'h800000, 8'h01, 1, 4'hA, 0, 0, 0, 0));
    drain();

    // Random beats at full throughput
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: rs = {1'b1, 24'($urandom)};
        1: rs = 25'h0;
        default: rs = {1'b0, 24'($urandom) >> $urandom_range(0, 23)};
      endcase
      in_exp = 8'($urandom_range(0, 254));
      in_sign = 1'($urandom_range(0, 1));
      in_tag = 4'($urandom_range(0, 15));
      drive(rs, in_exp, in_sign, in_tag, model(rs, in_exp, in_sign, in_tag));
    end
    drain();

    // Backpressure: out_ready low for 5 cycles while 4 beats are offered
    out_ready = 1'b0;
    nxt = 0;
    snap = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (nxt < 4);
      in_sum = 25'h0400000 | 25'(nxt);
      in_exp = 8'h40; in_sign = 1'b0; in_tag = 4'(nxt + 1);
      @(negedge clk);
      if (c == 2) snap = obs_word;
      if (c > 2) check("bp_stable", 64'(obs_word), 64'(snap));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_sum, in_exp, in_sign, in_tag));
        nxt++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepted", 64'(nxt), 64'(2));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    check("bp_out_held", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = (nxt < 4);
      in_sum = 25'h0400000 | 25'(nxt);
      in_exp = 8'h40; in_sign = 1'b0; in_tag = 4'(nxt + 1);
      @(negedge clk);
      check("bp_order_valid", 64'(out_valid), 64'(1));
      check("bp_order_tag", 64'(out_tag), 64'(k));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_sum, in_exp, in_sign, in_tag));
        nxt++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // Reset mid-flight: two beats in the pipe are discarded
    drive(25'h0200000, 8'h20, 1, 4'hB, pack(24'h800000, 8'h1E, 1, 4'hB, 0, 0, 0, 0));
    drive(25'h1000002, 8'h20, 1, 4'hC, pack(24'h800001, 8'h21, 1, 4'hC, 0, 0, 0, 0));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_word", 64'(obs_word), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'(0));
    @(posedge clk); #1;

    drive(25'h0000001, 8'h30, 0, 4'hD, pack(24'h800000, 8'h19, 0, 4'hD, 0, 0, 0, 0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
